// File: rtl/sfifo_wb_pkg.sv
// Shared word map, CTRL bit positions and decode helpers for the motion-control
// Wishbone bridge and its mailbox serializer.
package sfifo_wb_pkg;

    localparam int IDX_BP_TICK = 0;
    localparam int IDX_CTRL    = 1;
    localparam int IDX_SFIFO   = 2;
    localparam int IDX_MBOX    = 3;
    localparam int IDX_RT_CMD  = 4;
    localparam int IDX_DIN     = 8;
    localparam int IDX_DIN_CHG = 12;
    localparam int IDX_DOUT    = 16;
    localparam int IDX_ESTOP   = 24;
    localparam int IDX_ADC     = 32;

    localparam int CTRL_SF_EMPTY = 0;
    localparam int CTRL_SF_FULL  = 1;
    localparam int CTRL_MB_FULL  = 2;
    localparam int CTRL_MB_AFULL = 3;
    localparam int CTRL_MB_EMPTY = 4;
    localparam int CTRL_TMO      = 5;
    localparam int CTRL_DIN_CHG  = 6;

    typedef enum logic [0:0] {
        MB_IDLE = 1'b0,
        MB_SEND = 1'b1
    } mbox_state_e;

    function automatic logic in_window(input int idx, input int base, input int n);
        return (idx >= base) && (idx < base + n);
    endfunction

    // Lowest selected byte lane; lane 0 leaves first.
    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/mbox_serializer.sv
// Sends the selected byte lanes of one 32-bit word to the mailbox FIFO,
// lane 0 first, one byte per cycle the mailbox is not full.
module mbox_serializer
    import sfifo_wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        full_i,
    output logic        wr_o,
    output logic [7:0]  byte_o,
    output mbox_state_e state_o
);

    mbox_state_e state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  lane;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MB_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    // mask & (mask - 1) drops the lane that is being sent this cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            MB_IDLE: begin
                if (start_i) begin
                    data_d = data_i;
                    mask_d = sel_i;
                    if (sel_i != 4'd0) state_d = MB_SEND;
                end
            end
            MB_SEND: begin
                if (!full_i) begin
                    mask_d = mask_q & (mask_q - 4'd1);
                    if ((mask_q & (mask_q - 4'd1)) == 4'd0) state_d = MB_IDLE;
                end
            end
            default: state_d = MB_IDLE;
        endcase
    end

    always_comb begin
        lane    = first_lane(mask_q);
        wr_o    = (state_q == MB_SEND) && !full_i;
        byte_o  = wr_o ? data_q[{lane, 3'b000} +: 8] : 8'd0;
        state_o = state_q;
    end

endmodule

// File: rtl/sfifo_wb_bridge.sv
// Wishbone slave bridging the OpenRISC bus to the motion-control datapath:
// sync-FIFO reader, mailbox writer, tick counter, DIN/DOUT/E-stop and ADC words.
module sfifo_wb_bridge
    import sfifo_wb_pkg::*;
#(
    parameter int WB_AW      = 8,
    parameter int SFIFO_DW   = 16,
    parameter int DIN_WORDS  = 3,
    parameter int DOUT_WORDS = 1,
    parameter int ADC_CH     = 16,
    parameter int ADC_W      = 12,
    parameter int SFIFO_TMO  = 64
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [WB_AW-1:2]          wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      sfifo_rd_o,
    input  logic                      sfifo_empty_i,
    input  logic                      sfifo_full_i,
    input  logic [SFIFO_DW-1:0]       sfifo_di,
    output logic                      mbox_wr_o,
    output logic [7:0]                mbox_do_o,
    input  logic                      mbox_full_i,
    input  logic                      mbox_afull_i,
    input  logic                      mbox_empty_i,
    input  logic                      sfifo_bp_tick_i,
    input  logic [31:0]               rt_cmd_i,
    output logic                      rt_cmd_rst_o,
    input  logic                      alarm_i,
    input  logic [32*DIN_WORDS-1:0]   din_i,
    output logic                      din_chg_o,
    output logic [32*DOUT_WORDS-1:0]  dout_o,
    input  logic [ADC_W*ADC_CH-1:0]   adc_i
);

    localparam int            TW       = $clog2(SFIFO_TMO) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(SFIFO_TMO - 1);

    int                         widx;
    logic                       req, acc, stall, tmo_hit, dec_err;
    logic                       is_bp, is_ctrl, is_sfifo, is_mbox, is_rt;
    logic [DIN_WORDS-1:0]       chg_sel;
    logic [DOUT_WORDS-1:0]      dout_sel, estop_sel;
    logic [31:0]                rd_word, ctrl_word, sfifo_word;
    logic                       ack_q, ack_d, err_q, err_d, rd_q, rd_d;
    logic [31:0]                dat_q, dat_d;
    logic [TW-1:0]              tmo_cnt_q, tmo_cnt_d;
    logic                       tmo_sticky_q, tmo_sticky_d;
    logic [2:0]                 bp_sync_q;
    logic                       bp_rise;
    logic [31:0]                bp_cnt_q, bp_cnt_d;
    logic [31:0]                rt_q;
    logic                       rt_sel, rt_sel_q;
    logic [32*DIN_WORDS-1:0]    din_prev_q, chg_q, chg_d;
    logic [DOUT_WORDS-1:0][31:0] dout_q, dout_d, estop_q, estop_d;
    mbox_state_e                mbox_state;
    logic                       mbox_start;

    assign widx = int'(wb_adr_i);

    // Handshake: a request is cyc&stb while no response is pending. An unstalled
    // request gets a registered one-cycle ack or err on the next edge; stalled
    // requests wait with nothing asserted and the master holds cyc/stb/adr/dat.
    assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign stall   = (is_sfifo & ~wb_we_i & sfifo_empty_i)
                   | (is_mbox & wb_we_i & ((mbox_state != MB_IDLE) | mbox_full_i));
    assign tmo_hit = req & is_sfifo & ~wb_we_i & sfifo_empty_i & (tmo_cnt_q == TMO_LAST);
    assign acc     = req & ~dec_err & ~stall;
    assign ack_d   = acc;
    assign err_d   = req & (dec_err | tmo_hit);
    assign rd_d    = acc & is_sfifo & ~wb_we_i;
    assign dat_d   = (acc & ~wb_we_i) ? rd_word : 32'd0;
    assign mbox_start = acc & is_mbox & wb_we_i;
    assign rt_sel  = req & is_rt;
    assign bp_rise = bp_sync_q[1] & ~bp_sync_q[2];
    assign sfifo_word = 32'(sfifo_di) << (32 - SFIFO_DW);

    always_comb begin
        ctrl_word                = '0;
        ctrl_word[CTRL_SF_EMPTY] = sfifo_empty_i;
        ctrl_word[CTRL_SF_FULL]  = sfifo_full_i;
        ctrl_word[CTRL_MB_FULL]  = mbox_full_i;
        ctrl_word[CTRL_MB_AFULL] = mbox_afull_i;
        ctrl_word[CTRL_MB_EMPTY] = mbox_empty_i;
        ctrl_word[CTRL_TMO]      = tmo_sticky_q;
        ctrl_word[CTRL_DIN_CHG]  = din_chg_o;
    end

    always_comb begin
        rd_word   = '0;
        dec_err   = 1'b1;
        is_bp     = 1'b0;
        is_ctrl   = 1'b0;
        is_sfifo  = 1'b0;
        is_mbox   = 1'b0;
        is_rt     = 1'b0;
        chg_sel   = '0;
        dout_sel  = '0;
        estop_sel = '0;
        if (widx == IDX_BP_TICK) begin
            dec_err = 1'b0; is_bp = 1'b1; rd_word = bp_cnt_q;
        end else if (widx == IDX_CTRL) begin
            dec_err = wb_we_i; is_ctrl = 1'b1; rd_word = ctrl_word;
        end else if (widx == IDX_SFIFO) begin
            dec_err = wb_we_i; is_sfifo = 1'b1; rd_word = sfifo_word;
        end else if (widx == IDX_MBOX) begin
            dec_err = 1'b0; is_mbox = 1'b1;
        end else if (widx == IDX_RT_CMD) begin
            dec_err = wb_we_i; is_rt = 1'b1; rd_word = rt_q;
        end else if (in_window(widx, IDX_DIN, DIN_WORDS) || in_window(widx, IDX_DIN_CHG, DIN_WORDS)
                     || in_window(widx, IDX_ADC, ADC_CH / 2)) begin
            dec_err = wb_we_i;
        end else if (in_window(widx, IDX_DOUT, DOUT_WORDS) || in_window(widx, IDX_ESTOP, DOUT_WORDS)) begin
            dec_err = 1'b0;
        end
        for (int i = 0; i < DIN_WORDS; i++) begin
            if (widx == IDX_DIN + i) rd_word = din_i[i*32 +: 32];
            if (widx == IDX_DIN_CHG + i) begin
                rd_word = chg_q[i*32 +: 32]; chg_sel[i] = 1'b1;
            end
        end
        for (int j = 0; j < DOUT_WORDS; j++) begin
            if (widx == IDX_DOUT + j) begin
                rd_word = dout_q[j]; dout_sel[j] = 1'b1;
            end
            if (widx == IDX_ESTOP + j) begin
                rd_word = estop_q[j]; estop_sel[j] = 1'b1;
            end
        end
        for (int k = 0; k < ADC_CH / 2; k++) begin
            if (widx == IDX_ADC + k)
                rd_word = {16'(adc_i[(2*k)*ADC_W +: ADC_W]), 16'(adc_i[(2*k+1)*ADC_W +: ADC_W])};
        end
    end

    always_comb begin
        bp_cnt_d = bp_cnt_q;
        if (acc && wb_we_i && is_bp) bp_cnt_d = wb_dat_i;
        else if (bp_rise)            bp_cnt_d = bp_cnt_q + 32'd1;

        tmo_cnt_d = (req && is_sfifo && !wb_we_i && sfifo_empty_i && !tmo_hit) ? tmo_cnt_q + TW'(1) : '0;
        tmo_sticky_d = tmo_sticky_q;
        if (tmo_hit)                             tmo_sticky_d = 1'b1;
        else if (acc && !wb_we_i && is_ctrl)     tmo_sticky_d = 1'b0;

        // A clearing read keeps only the changes seen in the same cycle.
        chg_d = chg_q | (din_i ^ din_prev_q);
        for (int i = 0; i < DIN_WORDS; i++) begin
            if (acc && !wb_we_i && chg_sel[i])
                chg_d[i*32 +: 32] = din_i[i*32 +: 32] ^ din_prev_q[i*32 +: 32];
        end

        dout_d  = dout_q;
        estop_d = estop_q;
        for (int j = 0; j < DOUT_WORDS; j++) begin
            for (int b = 0; b < 4; b++) begin
                if (acc && wb_we_i && estop_sel[j] && wb_sel_i[b])
                    estop_d[j][b*8 +: 8] = wb_dat_i[b*8 +: 8];
                if (!alarm_i && acc && wb_we_i && dout_sel[j] && wb_sel_i[b])
                    dout_d[j][b*8 +: 8] = wb_dat_i[b*8 +: 8];
            end
            if (alarm_i) dout_d[j] = estop_q[j];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= 1'b0;
            dat_q        <= '0;
            tmo_cnt_q    <= '0;
            tmo_sticky_q <= 1'b0;
            bp_sync_q    <= '0;
            bp_cnt_q     <= '0;
            rt_q         <= '0;
            rt_sel_q     <= 1'b0;
            din_prev_q   <= '0;
            chg_q        <= '0;
            dout_q       <= '0;
            estop_q      <= '0;
        end else begin
            ack_q        <= ack_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
            dat_q        <= dat_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_sticky_q <= tmo_sticky_d;
            bp_sync_q    <= {bp_sync_q[1:0], sfifo_bp_tick_i};
            bp_cnt_q     <= bp_cnt_d;
            rt_q         <= rt_cmd_i;
            rt_sel_q     <= rt_sel;
            din_prev_q   <= din_i;
            chg_q        <= chg_d;
            dout_q       <= dout_d;
            estop_q      <= estop_d;
        end
    end

    mbox_serializer u_mbox (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .start_i (mbox_start),
        .data_i  (wb_dat_i),
        .sel_i   (wb_sel_i),
        .full_i  (mbox_full_i),
        .wr_o    (mbox_wr_o),
        .byte_o  (mbox_do_o),
        .state_o (mbox_state)
    );

    assign wb_ack_o     = ack_q;
    assign wb_err_o     = err_q;
    assign wb_dat_o     = dat_q;
    assign sfifo_rd_o   = rd_q;
    assign rt_cmd_rst_o = rt_sel | rt_sel_q;
    assign din_chg_o    = |chg_q;
    assign dout_o       = dout_q;

endmodule

// File: tb/tb_sfifo_wb_bridge.sv
// Directed bench for sfifo_wb_bridge: bus responses and mailbox bytes are
// queued when issued and checked by monitors when the DUT presents them.
module tb_sfifo_wb_bridge;

  localparam int DIN_WORDS  = 3;
  localparam int DOUT_WORDS = 1;
  localparam int ADC_CH     = 16;
  localparam int ADC_W      = 12;
  localparam int SFIFO_TMO  = 64;
  localparam int BUDGET     = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [5:0]  adr = 6'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, sfifo_rd_o;
  logic        sfifo_empty = 1'b1, sfifo_full = 1'b0;
  logic [15:0] sfifo_di = 16'd0;
  logic        mbox_wr_o;
  logic [7:0]  mbox_do_o;
  logic        mbox_full = 1'b0, mbox_afull = 1'b0, mbox_empty = 1'b1;
  logic        bp_tick = 1'b0;
  logic [31:0] rt_cmd = 32'd0;
  logic        rt_cmd_rst_o;
  logic        alarm = 1'b0;
  logic [32*DIN_WORDS-1:0]  din = '0;
  logic                     din_chg_o;
  logic [32*DOUT_WORDS-1:0] dout_o;
  logic [ADC_W*ADC_CH-1:0]  adc = '0;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int mbox_wr_cnt = 0;
  logic [39:0] exp_q[$];  // {word index, check data, expect err, data}
  logic [7:0]  mbox_q[$];
  logic [39:0] e;

  sfifo_wb_bridge #(
    .WB_AW(8), .SFIFO_DW(16), .DIN_WORDS(DIN_WORDS), .DOUT_WORDS(DOUT_WORDS),
    .ADC_CH(ADC_CH), .ADC_W(ADC_W), .SFIFO_TMO(SFIFO_TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .sfifo_rd_o(sfifo_rd_o),
    .sfifo_empty_i(sfifo_empty), .sfifo_full_i(sfifo_full), .sfifo_di(sfifo_di),
    .mbox_wr_o(mbox_wr_o), .mbox_do_o(mbox_do_o), .mbox_full_i(mbox_full),
    .mbox_afull_i(mbox_afull), .mbox_empty_i(mbox_empty), .sfifo_bp_tick_i(bp_tick),
    .rt_cmd_i(rt_cmd), .rt_cmd_rst_o(rt_cmd_rst_o), .alarm_i(alarm), .din_i(din),
    .din_chg_o(din_chg_o), .dout_o(dout_o), .adc_i(adc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic xfer(input logic w, input int idx, input logic [3:0] s, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_data, output int lat);
    exp_q.push_back({6'(idx), ~w & ~exp_err, exp_err, exp_data});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = 6'(idx); wdat = d;
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      chk($sformatf("bus_timeout@%0d", idx), 32'(lat), 32'd1);
      void'(exp_q.pop_back());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp);
    int lat;
    xfer(1'b0, idx, 4'hF, 32'd0, 1'b0, exp, lat);
  endtask

  task automatic wr(input int idx, input logic [3:0] s, input logic [31:0] d);
    int lat;
    xfer(1'b1, idx, s, d, 1'b0, 32'd0, lat);
  endtask

  task automatic bus_err(input logic w, input int idx);
    int lat;
    xfer(w, idx, 4'hF, 32'h1234_5678, 1'b1, 32'd0, lat);
  endtask

  task automatic bp_pulse();
    @(posedge clk); #3 bp_tick = 1'b1;
    repeat (3) @(posedge clk);
    #3 bp_tick = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (wb_ack_o || wb_err_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: ack=%b err=%b dat=0x%08h with nothing expected", wb_ack_o, wb_err_o, wb_dat_o);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("resp_err@%0d", e[39:34]), 32'(wb_err_o), 32'(e[32]));
        chk($sformatf("ack_err_excl@%0d", e[39:34]), 32'(wb_ack_o & wb_err_o), 32'd0);
        if (e[33]) chk($sformatf("resp_data@%0d", e[39:34]), wb_dat_o, e[31:0]);
      end
    end
    if (sfifo_rd_o) begin
      pop_cnt++;
      chk("pop_with_ack", 32'(wb_ack_o), 32'd1);
    end
    if (mbox_wr_o) begin
      mbox_wr_cnt++;
      chk("mbox_wr_while_full", 32'(mbox_full), 32'd0);
      if (mbox_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_mbox_byte: got 0x%02h with nothing expected", mbox_do_o);
      end else begin
        chk("mbox_byte", 32'(mbox_do_o), 32'(mbox_q.pop_front()));
      end
    end
  end

  initial begin
    int lat, p0, w0;
    for (int c = 0; c < ADC_CH; c++) adc[c*ADC_W +: ADC_W] = 12'h100 + 12'(c);
    rt_cmd = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_flags", 32'({wb_ack_o, wb_err_o, sfifo_rd_o, mbox_wr_o, din_chg_o, rt_cmd_rst_o}), 32'd0);
    chk("reset_dat", wb_dat_o, 32'd0);
    chk("reset_dout", dout_o, 32'd0);

    // CTRL after reset: sfifo empty + mbox empty, single-cycle latency
    xfer(1'b0, 1, 4'hF, 32'd0, 1'b0, 32'h0000_0011, lat);
    chk("ctrl_latency", 32'(lat), 32'd1);

    // FIFO head read
    sfifo_empty = 1'b0; sfifo_di = 16'hBEEF;
    p0 = pop_cnt;
    xfer(1'b0, 2, 4'hF, 32'd0, 1'b0, 32'hBEEF_0000, lat);
    sfifo_empty = 1'b1;
    chk("sfifo_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    chk("sfifo_one_pop", 32'(pop_cnt - p0), 32'd1);

    // FIFO timeout
    p0 = pop_cnt;
    xfer(1'b0, 2, 4'hF, 32'd0, 1'b1, 32'd0, lat);
    chk("tmo_latency", 32'(lat), 32'(SFIFO_TMO));
    chk("tmo_no_pop", 32'(pop_cnt - p0), 32'd0);
    rd(1, 32'h0000_0031);
    rd(1, 32'h0000_0011);

    // mailbox: lanes 1 and 3, backpressure in the middle
    w0 = mbox_wr_cnt;
    mbox_q.push_back(8'h22); mbox_q.push_back(8'h44);
    wr(3, 4'b1010, 32'h4433_2211);
    @(posedge clk); #1;
    mbox_full = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mbox_held_byte_pending", 32'(mbox_q.size()), 32'd1);
    mbox_full = 1'b0;
    @(posedge clk); #1;
    chk("mbox_partial_count", 32'(mbox_wr_cnt - w0), 32'd2);

    // mailbox stalls the bus while full
    mbox_full = 1'b1;
    mbox_q.push_back(8'hEE);
    fork
      xfer(1'b1, 3, 4'b0001, 32'h0000_00EE, 1'b0, 32'd0, lat);
      begin
        repeat (5) @(posedge clk);
        #1 mbox_full = 1'b0;
      end
    join
    chk("mbox_stall_latency", 32'(lat), 32'd5);

    // four lanes back to back, then sel=0
    mbox_q.push_back(8'hAA); mbox_q.push_back(8'hBB);
    mbox_q.push_back(8'hCC); mbox_q.push_back(8'hDD);
    wr(3, 4'b1111, 32'hDDCC_BBAA);
    repeat (4) @(posedge clk);
    #1 chk("mbox_burst_4_cycles", 32'(mbox_q.size()), 32'd0);
    w0 = mbox_wr_cnt;
    wr(3, 4'b0000, 32'h5555_5555);
    repeat (3) @(posedge clk);
    #1 chk("mbox_sel0_no_bytes", 32'(mbox_wr_cnt - w0), 32'd0);

    // DIN change capture
    din[32 + 5] = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("din_chg_flag", 32'(din_chg_o), 32'd1);
    rd(9, 32'h0000_0020);
    rd(13, 32'h0000_0020);
    rd(13, 32'h0000_0000);
    chk("din_chg_cleared", 32'(din_chg_o), 32'd0);

    // DOUT / ESTOP / alarm
    wr(16, 4'b0001, 32'h0000_00A5);
    chk("dout_write", dout_o, 32'h0000_00A5);
    wr(24, 4'b0001, 32'h0000_003C);
    alarm = 1'b1;
    @(posedge clk); #1;
    chk("dout_estop", dout_o, 32'h0000_003C);
    wr(16, 4'b1111, 32'hFFFF_FFFF);
    rd(16, 32'h0000_003C);
    alarm = 1'b0;
    wr(16, 4'b0110, 32'h1234_5678);
    chk("dout_lanes", dout_o, 32'h0034_563C);
    rd(24, 32'h0000_003C);

    // RT command readback and reset pulse
    rd(4, 32'hCAFE_F00D);
    chk("rt_rst_delayed", 32'(rt_cmd_rst_o), 32'd1);
    @(posedge clk); #1;
    chk("rt_rst_low", 32'(rt_cmd_rst_o), 32'd0);

    // ADC pairs
    rd(32, 32'h0100_0101);
    rd(39, 32'h010E_010F);

    // decode errors
    bus_err(1'b0, 63);
    bus_err(1'b1, 1);
    bus_err(1'b1, 2);
    bus_err(1'b0, 11);
    bus_err(1'b0, 17);
    bus_err(1'b0, 40);

    // base-period tick counter
    repeat (5) bp_pulse();
    rd(0, 32'd5);
    wr(0, 4'hF, 32'hFFFF_FFFF);
    bp_pulse();
    rd(0, 32'd0);

    // reset while the mailbox is mid-send
    din = '0;
    repeat (2) @(posedge clk);
    w0 = mbox_wr_cnt;
    mbox_q.push_back(8'hAA);
    wr(3, 4'b1111, 32'hDDCC_BBAA);
    @(posedge clk); #1;
    mbox_full = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    mbox_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("reset_aborts_send", 32'(mbox_wr_cnt - w0), 32'd1);
    chk("reset_dout_again", dout_o, 32'd0);
    rd(1, 32'h0000_0011);

    repeat (3) @(posedge clk);
    #1 chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("mbox_queue_drained", 32'(mbox_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
